// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU (read-only) and the LSU (read/write).
// The winning requester owns the port from handshake until its single response returns.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic                    lsu_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
  output logic                    lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;

  logic grant_ifu_s;
  logic grant_lsu_s;

  // State and request-latch registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_LSU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

  // Next-state, grant selection and all port outputs.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_rdata      = '0;
    mem_req_valid  = 1'b0;
    mem_addr       = addr_q;
    mem_wen        = wen_q;
    mem_wdata      = wdata_q;
    mem_wmask      = wmask_q;

    // A lone requester always wins; under contention the one not served last wins.
    grant_ifu_s = ifu_req_valid && (!lsu_req_valid || (last_grant_q == OWN_LSU));
    grant_lsu_s = lsu_req_valid && !grant_ifu_s;

    case (state_q)
      S_IDLE: begin
        ifu_req_ready = grant_ifu_s;
        lsu_req_ready = grant_lsu_s;
        if (grant_ifu_s) begin
          state_d      = S_REQ;
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          addr_d       = ifu_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
        end else if (grant_lsu_s) begin
          state_d      = S_REQ;
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          addr_d       = lsu_addr;
          wen_d        = lsu_wen;
          wdata_d      = lsu_wdata;
          wmask_d      = lsu_wmask;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = S_RESP;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          state_d = S_IDLE;
          if (owner_q == OWN_IFU) begin
            ifu_resp_valid = 1'b1;
            ifu_rdata      = mem_rdata;
          end else begin
            lsu_resp_valid = 1'b1;
            lsu_rdata      = wen_q ? '0 : mem_rdata;
          end
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // While reset is held every output is forced quiet, even mid-transaction.
    if (rst) begin
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      ifu_rdata      = '0;
      lsu_rdata      = '0;
      mem_req_valid  = 1'b0;
      mem_addr       = '0;
      mem_wen        = 1'b0;
      mem_wdata      = '0;
      mem_wmask      = '0;
    end else begin
      mem_addr = addr_q;
    end
  end

endmodule
